// File: rtl/block_mult_sequencer.sv
// Block matrix-multiply sequencer: walks k/row/col tiles, drives RAM addresses.
// Optional abort input enabled by defining BLOCK_SEQ_ABORT_EN.
module block_mult_sequencer #(
  parameter int K_TILES = 16,
  parameter int N_ROWS  = 128,
  parameter int N_COLS  = 128,
  parameter int ADDR_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              done_systolic,
  input  logic              done_accum,
`ifdef BLOCK_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              sys_reset,
  output logic              accum_reset,
  output logic              out_valid,
  output logic [15:0]       out_row,
  output logic [15:0]       out_col,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    ACCUM_WAIT,
    EMIT,
    FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       k_q, k_d;
  logic [15:0]       row_q, row_d;
  logic [15:0]       col_q, col_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic              abort_w;
  logic              k_last;
  logic              blk_last;

`ifdef BLOCK_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign k_last   = (k_q == 16'(K_TILES - 1));
  assign blk_last = (row_q == 16'(N_ROWS - 1))
                 && (col_q == 16'(N_COLS - 1));

  // Next-state and tile counter sequencing
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    row_d   = row_q;
    col_d   = col_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          k_d     = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      LOAD: state_d = COMPUTE;
      COMPUTE: begin
        if (done_systolic) begin
          if (!k_last) begin
            k_d     = k_q + 16'd1;
            state_d = LOAD;
          end else if (done_accum) begin
            state_d = EMIT;
          end else begin
            state_d = ACCUM_WAIT;
          end
        end
      end
      ACCUM_WAIT: begin
        if (done_accum) state_d = EMIT;
      end
      EMIT: begin
        k_d = '0;
        if (blk_last) begin
          state_d = FINISH;
        end else begin
          state_d = LOAD;
          if (col_q == 16'(N_COLS - 1)) begin
            col_d = '0;
            row_d = row_q + 16'd1;
          end else begin
            col_d = col_q + 16'd1;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        k_d     = '0;
        row_d   = '0;
        col_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    if (abort_w && state_q != IDLE) begin
      state_d = IDLE;
      k_d     = '0;
      row_d   = '0;
      col_d   = '0;
    end
  end

  // Tile addresses computed from the counters the LOAD cycle will use
  always_comb begin
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    if (state_d == LOAD) begin
      addr_a_d = ADDR_W'(32'(k_d) + 32'(K_TILES) * 32'(row_d));
      addr_b_d = ADDR_W'(32'(k_d) + 32'(K_TILES) * 32'(col_d));
    end else if (state_d == IDLE) begin
      addr_a_d = '0;
      addr_b_d = '0;
    end
  end

  // State, counter and address registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      row_q    <= '0;
      col_q    <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      row_q    <= row_d;
      col_q    <= col_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
    end
  end

  // Control strobes decoded from the current state
  always_comb begin
    sys_reset   = 1'b0;
    accum_reset = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    unique case (state_q)
      IDLE: begin
        sys_reset   = 1'b1;
        accum_reset = 1'b1;
        busy        = 1'b0;
      end
      LOAD:       sys_reset = 1'b1;
      COMPUTE:    sys_reset = 1'b0;
      ACCUM_WAIT: sys_reset = 1'b0;
      EMIT: begin
        out_valid   = 1'b1;
        accum_reset = 1'b1;
      end
      FINISH: begin
        done        = 1'b1;
        sys_reset   = 1'b1;
        accum_reset = 1'b1;
      end
      default: begin
        sys_reset   = 1'b1;
        accum_reset = 1'b1;
        busy        = 1'b0;
      end
    endcase
  end

  assign addr_a  = addr_a_q;
  assign addr_b  = addr_b_q;
  assign out_row = row_q;
  assign out_col = col_q;

endmodule

// File: tb/tb_block_mult_sequencer.sv
// Directed bench for block_mult_sequencer: small 2x2x2 run plus default-size
// corner cases (same-cycle accum, column wrap, async reset, stray inputs).
module tb_block_mult_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  logic start, dsys, dacc;
  bit   sel;
`ifdef BLOCK_SEQ_ABORT_EN
  logic abort;
`endif

  logic [15:0] s_aa, s_ab, s_row, s_col;
  logic        s_sr, s_ar, s_ov, s_busy, s_done;
  logic [15:0] d_aa, d_ab, d_row, d_col;
  logic        d_sr, d_ar, d_ov, d_busy, d_done;

  logic s_start, s_dsys, s_dacc, d_start, d_dsys, d_dacc;
  assign s_start = start & ~sel;
  assign s_dsys  = dsys  & ~sel;
  assign s_dacc  = dacc  & ~sel;
  assign d_start = start & sel;
  assign d_dsys  = dsys  & sel;
  assign d_dacc  = dacc  & sel;

`ifdef BLOCK_SEQ_ABORT_EN
  logic s_abort, d_abort;
  assign s_abort = abort & ~sel;
  assign d_abort = abort & sel;
`endif

  block_mult_sequencer #(
    .K_TILES(2), .N_ROWS(2), .N_COLS(2), .ADDR_W(16)
  ) u_small (
    .clock(clock), .reset(reset), .start(s_start),
    .done_systolic(s_dsys), .done_accum(s_dacc),
`ifdef BLOCK_SEQ_ABORT_EN
    .abort(s_abort),
`endif
    .addr_a(s_aa), .addr_b(s_ab),
    .sys_reset(s_sr), .accum_reset(s_ar),
    .out_valid(s_ov), .out_row(s_row), .out_col(s_col),
    .busy(s_busy), .done(s_done)
  );

  block_mult_sequencer u_def (
    .clock(clock), .reset(reset), .start(d_start),
    .done_systolic(d_dsys), .done_accum(d_dacc),
`ifdef BLOCK_SEQ_ABORT_EN
    .abort(d_abort),
`endif
    .addr_a(d_aa), .addr_b(d_ab),
    .sys_reset(d_sr), .accum_reset(d_ar),
    .out_valid(d_ov), .out_row(d_row), .out_col(d_col),
    .busy(d_busy), .done(d_done)
  );

  logic [15:0] o_aa, o_ab, o_row, o_col;
  logic        o_sr, o_ar, o_ov, o_busy, o_done;
  assign o_aa   = sel ? d_aa   : s_aa;
  assign o_ab   = sel ? d_ab   : s_ab;
  assign o_row  = sel ? d_row  : s_row;
  assign o_col  = sel ? d_col  : s_col;
  assign o_sr   = sel ? d_sr   : s_sr;
  assign o_ar   = sel ? d_ar   : s_ar;
  assign o_ov   = sel ? d_ov   : s_ov;
  assign o_busy = sel ? d_busy : s_busy;
  assign o_done = sel ? d_done : s_done;

  int checks = 0;
  int errors = 0;
  int s_ov_cnt = 0;
  int s_done_cnt = 0;
  int d_done_cnt = 0;

  always @(negedge clock) begin
    if (s_ov)   s_ov_cnt++;
    if (s_done) s_done_cnt++;
    if (d_done) d_done_cnt++;
  end

  typedef struct {
    int          sdly;
    int          adly;
    bit          last;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [15:0] er;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl [8];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_addr_a"}, o_aa, 16'd0);
    chk({nm, "_addr_b"}, o_ab, 16'd0);
    chk({nm, "_row"}, o_row, 16'd0);
    chk({nm, "_col"}, o_col, 16'd0);
    chk1({nm, "_valid"}, o_ov, 1'b0);
    chk1({nm, "_done"}, o_done, 1'b0);
    chk1({nm, "_busy"}, o_busy, 1'b0);
    chk1({nm, "_sys_reset"}, o_sr, 1'b1);
    chk1({nm, "_accum_reset"}, o_ar, 1'b1);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entry: DUT in LOAD. Exit: DUT in next LOAD, or the cycle after EMIT.
  task automatic do_tile(input int sdly, input int adly, input bit last,
                         input logic [15:0] ea, input logic [15:0] eb,
                         input logic [15:0] er, input logic [15:0] ec);
    chk("load_addr_a", o_aa, ea);
    chk("load_addr_b", o_ab, eb);
    chk1("load_sys_reset", o_sr, 1'b1);
    tick();
    chk1("compute_sys_reset", o_sr, 1'b0);
    repeat (sdly - 1) tick();
    dsys = 1'b1;
    if (last && adly == 0) dacc = 1'b1;
    tick();
    dsys = 1'b0;
    dacc = 1'b0;
    if (last) begin
      if (adly > 0) begin
        chk1("accum_wait_no_valid", o_ov, 1'b0);
        repeat (adly - 1) tick();
        dacc = 1'b1;
        tick();
        dacc = 1'b0;
      end
      chk1("emit_valid", o_ov, 1'b1);
      chk("emit_row", o_row, er);
      chk("emit_col", o_col, ec);
      chk1("emit_accum_reset", o_ar, 1'b1);
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    dsys  = 1'b0;
    dacc  = 1'b0;
    sel   = 1'b0;
`ifdef BLOCK_SEQ_ABORT_EN
    abort = 1'b0;
`endif

    tbl[0] = '{3, 2, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0};
    tbl[1] = '{3, 2, 1'b1, 16'd1, 16'd1, 16'd0, 16'd0};
    tbl[2] = '{3, 2, 1'b0, 16'd0, 16'd2, 16'd0, 16'd1};
    tbl[3] = '{3, 2, 1'b1, 16'd1, 16'd3, 16'd0, 16'd1};
    tbl[4] = '{3, 2, 1'b0, 16'd2, 16'd0, 16'd1, 16'd0};
    tbl[5] = '{3, 2, 1'b1, 16'd3, 16'd1, 16'd1, 16'd0};
    tbl[6] = '{3, 2, 1'b0, 16'd2, 16'd2, 16'd1, 16'd1};
    tbl[7] = '{3, 2, 1'b1, 16'd3, 16'd3, 16'd1, 16'd1};

    tick();
    tick();
    chk_reset_vals("rst_small");
    sel = 1'b1;
    #1;
    chk_reset_vals("rst_def");
    sel = 1'b0;
    reset = 1'b1;
    tick();
    chk1("idle_sys_reset", o_sr, 1'b1);
    chk1("idle_accum_reset", o_ar, 1'b1);
    chk1("idle_busy", o_busy, 1'b0);

    // 2x2x2 full run
    pulse_start();
    for (int i = 0; i < 8; i++)
      do_tile(tbl[i].sdly, tbl[i].adly, tbl[i].last,
              tbl[i].ea, tbl[i].eb, tbl[i].er, tbl[i].ec);
    chk1("finish_done", o_done, 1'b1);
    chk1("finish_busy", o_busy, 1'b1);
    tick();
    chk1("post_done", o_done, 1'b0);
    chk1("post_busy", o_busy, 1'b0);
    chk1("post_sys_reset", o_sr, 1'b1);
    chk1("post_accum_reset", o_ar, 1'b1);
    tick();
    checks++;
    if (s_ov_cnt != 4) begin
      errors++;
      $display("FAIL small_valid_count actual=%0d required=4", s_ov_cnt);
    end
    checks++;
    if (s_done_cnt != 1) begin
      errors++;
      $display("FAIL small_done_count actual=%0d required=1", s_done_cnt);
    end

    // Default size: block (0,0) with stray inputs at k=3
    sel = 1'b1;
    #1;
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      if (k == 3) begin
        chk("k3_load_addr_a", o_aa, 16'd3);
        tick();
        dacc  = 1'b1;
        start = 1'b1;
        tick();
        dacc  = 1'b0;
        start = 1'b0;
        chk("stray_addr_a", o_aa, 16'd3);
        chk("stray_addr_b", o_ab, 16'd3);
        chk1("stray_sys_reset", o_sr, 1'b0);
        chk1("stray_valid", o_ov, 1'b0);
        chk1("stray_busy", o_busy, 1'b1);
        chk("stray_row", o_row, 16'd0);
        dsys = 1'b1;
        tick();
        dsys = 1'b0;
      end else begin
        do_tile(1, 0, k == 15, 16'(k), 16'(k), 16'd0, 16'd0);
      end
    end

    // Rest of row 0, mixing accumulator latencies
    for (int c = 1; c < 128; c++)
      for (int k = 0; k < 16; k++)
        do_tile(1 + (c % 2), c % 3, k == 15,
                16'(k), 16'(k + 16 * c), 16'd0, 16'(c));
    chk("wrap_addr_a", o_aa, 16'd16);
    chk("wrap_addr_b", o_ab, 16'd0);
    for (int k = 0; k < 16; k++)
      do_tile(1, 1, k == 15, 16'(k + 16), 16'(k), 16'd1, 16'd0);

    // Async reset in COMPUTE at k=5 of block (1,1)
    for (int k = 0; k < 5; k++)
      do_tile(2, 0, 1'b0, 16'(k + 16), 16'(k + 16), 16'd1, 16'd1);
    chk("k5_addr_a", o_aa, 16'd21);
    tick();
    chk1("k5_compute", o_sr, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    #2;
    reset = 1'b1;
    tick();
    chk1("rst_idle_busy", o_busy, 1'b0);
    pulse_start();
    chk("restart_addr_a", o_aa, 16'd0);
    chk("restart_addr_b", o_ab, 16'd0);
    chk1("restart_busy", o_busy, 1'b1);

`ifdef BLOCK_SEQ_ABORT_EN
    for (int k = 0; k < 15; k++)
      do_tile(1, 0, 1'b0, 16'(k), 16'(k), 16'd0, 16'd0);
    tick();
    dsys = 1'b1;
    tick();
    dsys = 1'b0;
    chk1("accum_wait_busy", o_busy, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk1("abort_busy", o_busy, 1'b0);
    chk1("abort_done", o_done, 1'b0);
    chk1("abort_valid", o_ov, 1'b0);
    chk1("abort_sys_reset", o_sr, 1'b1);
    chk1("abort_accum_reset", o_ar, 1'b1);
    tick();
`endif

    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (d_done_cnt != 0) begin
      errors++;
      $display("FAIL def_done_count actual=%0d required=0", d_done_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_mult_sequencer.md
BLOCK_MULT_SEQUENCER -- requirements
Module: block_mult_sequencer

Interface
REQ-001 SHALL have parameter K_TILES, default 16, meaning inner-dimension tiles accumulated per output block.
REQ-002 SHALL have parameter N_ROWS, default 128, meaning output block rows.
REQ-003 SHALL have parameter N_COLS, default 128, meaning output block columns.
REQ-004 SHALL have parameter ADDR_W, default 16, meaning RAM tile-address width.
REQ-005 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  begin full multiplication; sampled only in IDLE.
REQ-008 SHALL have port done_systolic  input  1  systolic array finished one tile product.
REQ-009 SHALL have port done_accum  input  1  accumulator holds a complete output block.
REQ-010 SHALL have port addr_a  output  ADDR_W  A-tile RAM address.
REQ-011 SHALL have port addr_b  output  ADDR_W  B-tile RAM address.
REQ-012 SHALL have port sys_reset  output  1  active-high reset to the systolic array.
REQ-013 SHALL have port accum_reset  output  1  active-high reset to the accumulator.
REQ-014 SHALL have ports out_valid (1), out_row (16), out_col (16)  outputs  result-block strobe and its coordinates.
REQ-015 SHALL have ports busy (1) and done (1)  outputs  run in progress; one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, LOAD, COMPUTE, ACCUM_WAIT, EMIT, FINISH.
REQ-017 IDLE: start=1 -> LOAD with k=0, row=0, col=0; start ignored in every other state.
REQ-018 LOAD (exactly 1 cycle): addr_a=k+K_TILES*row, addr_b=k+K_TILES*col, both registered and truncated to ADDR_W; sys_reset=1; next state COMPUTE.
REQ-019 COMPUTE: sys_reset=0; addresses held; done_systolic=1 with k<K_TILES-1 -> k+1, LOAD; with k=K_TILES-1 -> ACCUM_WAIT.
REQ-020 ACCUM_WAIT: hold until done_accum=1, then EMIT; done_accum arriving in the same cycle as the final done_systolic SHALL go directly to EMIT.
REQ-021 done_accum outside COMPUTE(final k)/ACCUM_WAIT SHALL be ignored.
REQ-022 EMIT (exactly 1 cycle): out_valid=1, out_row/out_col = current block, accum_reset=1; then col wraps N_COLS-1 -> 0 with row+1; next LOAD with k=0, or FINISH when row=N_ROWS-1 and col=N_COLS-1.
REQ-023 FINISH: done=1 for one cycle, counters cleared, return to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE; EMIT-to-LOAD overhead is fixed at 1 cycle.

Reset
REQ-025 reset=0 SHALL immediately force IDLE, k=row=col=0, addr_a=addr_b=0, out_row=out_col=0, out_valid=done=busy=0, sys_reset=1, accum_reset=1.
REQ-026 In IDLE, sys_reset and accum_reset SHALL remain 1; reset asserted mid-run discards all progress, no done pulse.

Configuration
REQ-027 With macro BLOCK_SEQ_ABORT_EN defined, SHALL add input abort (1 bit): abort=1 in any non-IDLE state -> IDLE next cycle, sys_reset=accum_reset=1, no out_valid or done.
REQ-028 Without BLOCK_SEQ_ABORT_EN, no abort port exists and a run always completes.

Verification
REQ-029 K_TILES=2, N_ROWS=N_COLS=2, start, done_systolic 3 cycles after each LOAD, done_accum 2 cycles later -> addr_a/addr_b sequence (0,0),(1,1),(0,2),(1,3),(2,0),(3,1),(2,2),(3,3); 4 out_valid pulses (0,0),(0,1),(1,0),(1,1); one done pulse.
REQ-030 Defaults, done_accum same cycle as 16th done_systolic -> EMIT next cycle, no ACCUM_WAIT cycle, out_valid for (0,0).
REQ-031 Defaults, row=0, col=127 block emitted -> next LOAD addr_a=16, addr_b=0, out_row=1 on following emit.
REQ-032 reset=0 asynchronously during COMPUTE at k=5 -> outputs at REQ-025 values within same cycle; start afterwards restarts at addr 0/0.
REQ-033 Stray done_accum in COMPUTE at k=3 and start pulses while busy -> no state, counter or output change.
REQ-034 BLOCK_SEQ_ABORT_EN defined, abort in ACCUM_WAIT -> IDLE next cycle, busy=0, no done.
